sdu_sample_ram: RTL and testbench
=================================

Name: sdu_sample_ram

Overview:
- Simple dual-port, single-clock inferred RAM that holds the ultrasound TX sample sequence.
- The sample replay block writes one sample per PC strobe through the write port.
- The same block reads samples back in address order through the read port, which drives the DAC path directly.
- The RAM is sized to map onto FPGA block RAM and has one registered read port and one write port.

Parameters:
- DWIDTH, 16, data word width in bits. First positional parameter.
- AWIDTH, 16, address width in bits; depth = 2^AWIDTH words. Second positional parameter.

Ports:
- clk  input  1  system clock; all activity on the rising edge.
- reset  input  1  synchronous, active-high reset.
- rd_addr  input  AWIDTH  read address, sampled on the rising edge.
- rd_data  output  DWIDTH  registered read data.
- wr_addr  input  AWIDTH  write address.
- wr_data  input  DWIDTH  write data.
- wr_en  input  1  write enable; one word is written per cycle in which it is high.

Behaviour:
- One clock, clk. Reset is synchronous and active-high; it is sampled only on the rising edge of clk.
- Storage: 2^AWIDTH words of DWIDTH bits.
  - Every word is zero at configuration / simulation start, via an initial loop.
  - Reset does NOT clear the array contents.
- Write port:
  - On a rising edge with wr_en=1 and reset=0, mem[wr_addr] takes wr_data.
  - Writes are ignored while reset=1.
  - No write acknowledgement; the write completes at that edge.
- Read port:
  - Synchronous, with 1-cycle latency.
  - On a rising edge with reset=0, the rd_data register takes mem[rd_addr].
  - rd_data is therefore valid the cycle after rd_addr is presented.
  - There is no read enable; a read happens every cycle.
- Reset: on a rising edge with reset=1, rd_data becomes 0. It stays 0 for every cycle reset is held.
- Read/write collision:
  - Condition: same cycle, rd_addr == wr_addr, wr_en=1.
  - The behaviour is read-first: rd_data gets the OLD stored word.
  - The new word is visible on the next read of that address.
- Addresses are full-width and unsigned, so there is no out-of-range case. Callers' address counters wrap naturally from 2^AWIDTH-1 to 0.
- There is no handshake, back-pressure or status output.
- X/undriven inputs: the implementation is not required to handle them. The bench drives all inputs to known values after time 0.
- Coding requirements:
  - The array is described behaviourally so synthesis infers block RAM.
  - There is no reset term on the array.
  - The output register may use the block RAM's synchronous output-register reset.

Test Plan:
- Reset hold: assert reset 3 cycles with wr_en=1, wr_addr=5, wr_data=16'hDEAD -> rd_data=0 throughout. Afterwards, reading addr 5 returns 16'h0000 because the write was blocked.
- Write then read: write 16'h1234 @0, 16'hABCD @1, 16'hFFFF @65535. Then present rd_addr 0, 1, 65535 on consecutive cycles -> rd_data is 1234, ABCD, FFFF, each one cycle after its address.
- Sequential replay: write values 0..255 to addresses 0..255. Sweep rd_addr 0..255, one per cycle -> rd_data equals rd_addr delayed by exactly 1 cycle, with no gaps.
- Collision: mem[7]=16'h1111. In the same cycle, wr_en=1, wr_addr=7, wr_data=16'h2222, rd_addr=7 -> next cycle rd_data=16'h1111. Reading 7 again on the following cycle gives 16'h2222.
- Reset mid-stream: while sweeping reads, assert reset for 1 cycle -> rd_data=0 on the following cycle. The next read of a previously written address returns its original value, confirming contents are retained.
- Address wrap: write 16'h00AA @65535 and 16'h00BB @0. rd_addr counts 65534, 65535, 0 -> rd_data shows old[65534], 00AA, 00BB in successive cycles.

Source files
------------

// File: rtl/sdu_sample_ram.sv
// sdu_sample_ram: simple dual-port, single-clock RAM holding the ultrasound TX sample sequence.
// Latency: read data is registered, valid one cycle after rd_addr is presented; writes complete at the edge.
// Backpressure: none; one write (when wr_en) and one read happen every cycle, no handshake.
//
// Ports:
//   clk     - system clock, all activity on the rising edge
//   reset   - synchronous active-high reset; clears rd_data and blocks writes, keeps contents
//   rd_addr - read address, sampled on the rising edge
//   rd_data - registered read data (read-first on a same-address collision)
//   wr_addr - write address
//   wr_data - write data
//   wr_en   - write enable, one word written per cycle it is high
module sdu_sample_ram #(
  parameter int DWIDTH = 16,
  parameter int AWIDTH = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [AWIDTH-1:0] rd_addr,
  output logic [DWIDTH-1:0] rd_data,
  input  logic [AWIDTH-1:0] wr_addr,
  input  logic [DWIDTH-1:0] wr_data,
  input  logic              wr_en
);

  localparam int DEPTH = 1 << AWIDTH;

  logic [DWIDTH-1:0] mem_q [DEPTH];
  logic [DWIDTH-1:0] rd_data_q;
  logic [DWIDTH-1:0] rd_data_d;

  // Power-up contents are all zero; this becomes the block RAM's configuration image.
  initial begin
    for (int i = 0; i < DEPTH; i++) begin
      mem_q[i] = '0;
    end
  end

  // Array has no reset term so it maps onto block RAM. A plain clocked process
  // is used because the array is also given its power-up value above.
  always @(posedge clk) begin
    if (!reset && wr_en) begin
      mem_q[wr_addr] <= wr_data;
    end
  end

  // Reads the array before this edge's write lands, giving read-first
  // behaviour when rd_addr == wr_addr.
  always_comb begin
    rd_data_d = mem_q[rd_addr];
  end

  // Output register; its synchronous reset matches the block RAM output-register reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_data_q <= '0;
    end else begin
      rd_data_q <= rd_data_d;
    end
  end

  assign rd_data = rd_data_q;

endmodule

// File: tb/tb_sdu_sample_ram.sv
module tb_sdu_sample_ram;

  logic        clk;
  logic        reset;
  logic [15:0] rd_addr;
  logic [15:0] rd_data;
  logic [15:0] wr_addr;
  logic [15:0] wr_data;
  logic        wr_en;

  int checks;
  int failures;

  sdu_sample_ram #(.DWIDTH(16), .AWIDTH(16)) dut (
    .clk    (clk),
    .reset  (reset),
    .rd_addr(rd_addr),
    .rd_data(rd_data),
    .wr_addr(wr_addr),
    .wr_data(wr_data),
    .wr_en  (wr_en)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Advance one rising edge, then settle 1 time unit so outputs are sampled
  // and inputs changed away from the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [15:0] a, input logic [15:0] d);
    wr_en   = 1'b1;
    wr_addr = a;
    wr_data = d;
    step();
    wr_en   = 1'b0;
  endtask

  initial begin
    checks   = 0;
    failures = 0;

    // Reset held 3 cycles with a pending write to addr 5.
    reset   = 1'b1;
    wr_en   = 1'b1;
    wr_addr = 16'd5;
    wr_data = 16'hDEAD;
    rd_addr = 16'd5;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("reset_hold", rd_data, 16'h0000);
    end
    reset = 1'b0;
    wr_en = 1'b0;
    step();
    chk("write_blocked_in_reset", rd_data, 16'h0000);

    // Write then read back, including the top address.
    wr(16'd0, 16'h1234);
    wr(16'd1, 16'hABCD);
    wr(16'd65535, 16'hFFFF);
    rd_addr = 16'd0;
    step();
    chk("rd_addr0", rd_data, 16'h1234);
    rd_addr = 16'd1;
    step();
    chk("rd_addr1", rd_data, 16'hABCD);
    rd_addr = 16'd65535;
    step();
    chk("rd_addr65535", rd_data, 16'hFFFF);

    // Sequential replay: value == address, swept back-to-back.
    for (int i = 0; i < 256; i++) begin
      wr(16'(i), 16'(i));
    end
    for (int i = 0; i < 256; i++) begin
      rd_addr = 16'(i);
      step();
      chk("replay", rd_data, 16'(i));
    end

    // Collision: read-first returns the old word, new word visible next read.
    wr(16'd7, 16'h1111);
    wr_en   = 1'b1;
    wr_addr = 16'd7;
    wr_data = 16'h2222;
    rd_addr = 16'd7;
    step();
    wr_en = 1'b0;
    chk("collision_old", rd_data, 16'h1111);
    step();
    chk("collision_new", rd_data, 16'h2222);

    // Reset in the middle of a read sweep.
    rd_addr = 16'd10;
    step();
    chk("sweep_pre_reset", rd_data, 16'd10);
    rd_addr = 16'd11;
    reset   = 1'b1;
    step();
    chk("sweep_in_reset", rd_data, 16'h0000);
    reset = 1'b0;
    step();
    chk("retained_11", rd_data, 16'd11);
    rd_addr = 16'd12;
    step();
    chk("retained_12", rd_data, 16'd12);

    // Address wrap across 65535 -> 0; addr 65534 was never written.
    wr(16'd65535, 16'h00AA);
    wr(16'd0, 16'h00BB);
    rd_addr = 16'd65534;
    step();
    chk("wrap_65534", rd_data, 16'h0000);
    rd_addr = 16'd65535;
    step();
    chk("wrap_65535", rd_data, 16'h00AA);
    rd_addr = 16'd0;
    step();
    chk("wrap_0", rd_data, 16'h00BB);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
